sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment display controller. It is the successor to the team's fixed 4-digit hex mux and adds configurable digit count, refresh rate, output polarity, frame-coherent input capture, leading-zero suppression, per-digit blanking and PWM brightness. It sits between the score/status logic and the board's shared-segment LED display.

Parameters:
DIGITS, 4, number of multiplexed digits; legal range 1..8.
REFRESH_DIV, 65536, clk cycles per digit slot; power of two, >= 2**BRIGHT_W.
BRIGHT_W, 3, brightness control width.
AN_ACTIVE_LOW, 1, 1 means anodes are asserted low.
SEG_ACTIVE_LOW, 1, 1 means segments and dp are lit low.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hex_in  in  4*DIGITS  digit i = hex_in[4i+3:4i]; digit 0 is rightmost
dp_in  in  DIGITS  decimal point per digit, 1 = lit
blank_in  in  DIGITS  1 = force digit i dark
lz_en  in  1  leading-zero suppression enable
brightness  in  BRIGHT_W  0 = dimmest, all-ones = full
an  out  DIGITS  digit enables, polarity per AN_ACTIVE_LOW
sseg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse at end of each full scan

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset (and the cycle after it) drives these values:
  - prescaler = 0, digit index = 0, shadow registers = 0.
  - an = all inactive, sseg = all dark, frame_tick = 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On its terminal count, the index advances.
  - The index wraps from DIGITS-1 to 0.
- frame_tick = 1 for exactly one cycle when the prescaler is at terminal count and index = DIGITS-1.
- Frame snapshot: hex_in, dp_in, blank_in, lz_en and brightness load into shadow registers on every cycle where prescaler = 0 and index = 0. This includes the first cycle after reset release.
  - The display uses only the shadow registers.
  - Mid-frame input changes are invisible until the next frame.
- Leading-zero suppression (shadow values):
  - Digit i (i ≥ 1) is suppressed when lz_en = 1 and shadow digits DIGITS-1 down to i are all 0.
  - Digit 0 is never suppressed.
- Dark digit: the digit is dark if it is blanked or suppressed.
  - Segments a..g are off; the anode is still driven normally.
  - dp on a suppressed digit is still shown. blank_in forces dp off as well.
- PWM:
  - phase = prescaler >> (log2(REFRESH_DIV) - BRIGHT_W).
  - The anode is asserted only while phase <= shadow brightness; otherwise all anodes are inactive.
  - Minimum duty is 1/2**BRIGHT_W; all-ones gives 100 %.
- Decode (active-low gfedcba, inverted when SEG_ACTIVE_LOW = 0):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- an, sseg and frame_tick are registered: outputs at cycle t+1 reflect the counter and shadow state at cycle t. At most one anode is ever active.
- Reset mid-frame aborts the scan immediately. Outputs go dark on the next edge, and a fresh snapshot is taken on the first cycle after release.
- Illegal parameters are caught by a generate-time check that does not elaborate.

Decomposition:
- Package sseg_pkg holds:
  - the 16-entry active-low segment table,
  - constants SEG_OFF_AL = 8'hFF,
  - the polarity helper function.
- Sub-module hex_to_sseg: a combinational 4-bit to 7-segment decoder using the package table, instantiated once.

Test Plan:
Bench parameters: DIGITS=4, REFRESH_DIV=8, BRIGHT_W=2, both polarities active-low.
1. Reset held 3 cycles, hex_in=16'h1234, brightness=3 → during reset an=4'hF and sseg=8'hFF.
   - After release: an=4'b1110 with sseg=8'h99 for 8 cycles.
   - Then 4'b1101 with 8'hB0, 4'b1011 with 8'hA4, 4'b0111 with 8'hF9.
2. Frame coherence: set hex_in=16'h1234, then change it to 16'hABCD at cycle 12 → digits keep 1234 until the next frame start at cycle 32, then show D,C,B,A.
3. lz_en=1:
   - hex_in=16'h0050 → digits 3 and 2 give sseg=8'hFF with anode active; digit 1 gives 8'h92; digit 0 gives 8'hC0.
   - hex_in=16'h0000 → only digit 0 is lit.
4. brightness=0 → each anode is asserted 2 of 8 slot cycles (phase 0). brightness=2 → 6 of 8. dp_in=4'b0001 → sseg[7]=0 only in the digit-0 slot.
5. frame_tick: pulses every 32 cycles. Assert reset at cycle 45 → frame_tick stays 0, outputs go dark, and the scan restarts at digit 0.
6. blank_in=4'b0100 with dp_in=4'b0100 → the digit-2 slot gives sseg=8'hFF for the full slot.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment table,
// dark constant and output polarity helper.
package sseg_pkg;

    // Segment byte layout as driven on the board: {dp, g, f, e, d, c, b, a}.
    typedef struct packed {
        logic       dp;
        logic [6:0] gfedcba;
    } seg_t;

    // All segments and dp dark, in active-low form.
    localparam logic [7:0] SEG_OFF_AL = 8'hFF;

    // Active-low gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE_AL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Convert an active-low segment byte to the board polarity.
    function automatic logic [7:0] seg_pol(input logic [7:0] seg_al, input bit active_low);
        return active_low ? seg_al : ~seg_al;
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_hex_to_sseg.sv
// Combinational hex digit to active-low gfedcba decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the active-low segment pattern.
    always_comb begin
        seg = SEG_TABLE_AL[hex];
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment display controller with frame-coherent
// input capture, leading-zero suppression, per-digit blanking and PWM
// brightness. Outputs are registered one cycle after the scan state.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 65536,
    parameter int unsigned BRIGHT_W       = 3,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SH = (PW >= BRIGHT_W) ? (PW - BRIGHT_W) : 0;

    localparam logic [PW-1:0] CNT_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]        SEG_OFF = seg_pol(SEG_OFF_AL, SEG_ACTIVE_LOW);

    generate
        if (DIGITS < 1 || DIGITS > 8 || REFRESH_DIV < 2 ||
            (REFRESH_DIV & (REFRESH_DIV - 1)) != 0 || BRIGHT_W < 1 ||
            REFRESH_DIV < (1 << BRIGHT_W)) begin : g_bad_params
            $error("sseg_scan_ctrl: illegal parameter set");
        end
    endgenerate

    // Scan state
    logic [PW-1:0]         cnt;
    logic [IW-1:0]         idx;

    // Frame shadow registers
    logic [4*DIGITS-1:0]   sh_hex;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blank;
    logic                  sh_lz;
    logic [BRIGHT_W-1:0]   sh_bright;

    // Values used for display this cycle
    logic                  snap;
    logic [4*DIGITS-1:0]   view_hex;
    logic [DIGITS-1:0]     view_dp;
    logic [DIGITS-1:0]     view_blank;
    logic                  view_lz;
    logic [BRIGHT_W-1:0]   view_bright;

    logic [DIGITS-1:0]     supp;
    logic                  zero_run;
    logic [3:0]            cur_hex;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_supp;
    logic [6:0]            dec_seg;
    logic [BRIGHT_W-1:0]   phase;
    logic                  lit;
    logic [DIGITS-1:0]     an_mask;
    seg_t                  seg_al;
    logic                  tick_now;

    assign snap     = (cnt == '0) && (idx == '0);
    assign tick_now = (cnt == CNT_MAX) && (idx == IDX_MAX);

    // Prescaler and digit index; index steps on prescaler terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    // Capture all display inputs once per frame at the start of digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_hex    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= '0;
        end else if (snap) begin
            sh_hex    <= hex_in;
            sh_dp     <= dp_in;
            sh_blank  <= blank_in;
            sh_lz     <= lz_en;
            sh_bright <= brightness;
        end
    end

    // On the snapshot cycle the shadow registers are still being loaded,
    // so the freshly captured inputs are forwarded to keep the first slot
    // of the frame consistent with the rest of it.
    always_comb begin
        view_hex    = snap ? hex_in     : sh_hex;
        view_dp     = snap ? dp_in      : sh_dp;
        view_blank  = snap ? blank_in   : sh_blank;
        view_lz     = snap ? lz_en      : sh_lz;
        view_bright = snap ? brightness : sh_bright;
    end

    // Leading-zero mask: walk from the leftmost digit while digits stay zero.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run && (view_hex[4*(DIGITS-1-k) +: 4] == 4'h0);
            if (DIGITS - 1 - k != 0) begin
                supp[DIGITS-1-k] = view_lz && zero_run;
            end
        end
    end

    // Select the attributes of the digit currently being scanned.
    always_comb begin
        cur_hex   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (idx == IW'(d)) begin
                cur_hex   = view_hex[4*d +: 4];
                cur_dp    = view_dp[d];
                cur_blank = view_blank[d];
                cur_supp  = supp[d];
            end
        end
    end

    hex_to_sseg u_dec (
        .hex (cur_hex),
        .seg (dec_seg)
    );

    // Segment pattern (active-low) and PWM-gated anode mask for this slot.
    always_comb begin
        phase          = BRIGHT_W'(cnt >> SH);
        lit            = (phase <= view_bright);
        seg_al.gfedcba = (cur_blank || cur_supp) ? 7'h7F : dec_seg;
        seg_al.dp      = ~(cur_dp && !cur_blank);
        an_mask        = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (lit && idx == IW'(d)) begin
                an_mask[d] = 1'b1;
            end
        end
    end

    // Registered outputs in board polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= AN_OFF;
            sseg       <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= AN_ACTIVE_LOW ? ~an_mask : an_mask;
            sseg       <= seg_pol(seg_al, SEG_ACTIVE_LOW);
            frame_tick <= tick_now;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed self-checking bench for sseg_scan_ctrl (4 digits, 8-cycle slots,
// 2-bit brightness, active-low anodes and segments).
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hex_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        lz_en = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .DIGITS         (4),
        .REFRESH_DIV    (8),
        .BRIGHT_W       (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .brightness (brightness),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned multi_an = 0;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [1:0]  bright;
        int unsigned digit;
        logic [7:0]  exp_sseg;
        int unsigned exp_on;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [15:0] hex, input logic [3:0] dp,
                                input logic [3:0] blank, input logic lz,
                                input logic [1:0] bright, input int unsigned digit,
                                input logic [7:0] exp_sseg, input int unsigned exp_on);
        vec_t v;
        v.hex = hex; v.dp = dp; v.blank = blank; v.lz = lz; v.bright = bright;
        v.digit = digit; v.exp_sseg = exp_sseg; v.exp_on = exp_on;
        vecs.push_back(v);
    endfunction

    // Hold reset for n cycles, release on a falling edge.
    task automatic do_reset(input int unsigned n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // At most one anode may ever be active.
    always @(negedge clk) begin
        if (!$isunknown(an) && $countones(~an) > 1) multi_an++;
    end

    initial begin : main
        logic [7:0] old_exp [4];
        logic [7:0] new_exp [4];
        logic [7:0] seg_act;
        logic [3:0] an_act;
        logic [3:0] an_exp;
        int unsigned on_cnt;
        int unsigned pulses;
        int unsigned first_pulse;
        int unsigned last_pulse;

        // hex, dp, blank, lz, bright, digit, expected sseg, anode cycles per slot
        add(16'h1234, 4'h0, 4'h0, 1'b0, 2'd3, 0, 8'h99, 8);
        add(16'h1234, 4'h0, 4'h0, 1'b0, 2'd3, 1, 8'hB0, 8);
        add(16'h1234, 4'h0, 4'h0, 1'b0, 2'd3, 2, 8'hA4, 8);
        add(16'h1234, 4'h0, 4'h0, 1'b0, 2'd3, 3, 8'hF9, 8);
        add(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 3, 8'hFF, 8);
        add(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 2, 8'hFF, 8);
        add(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 1, 8'h92, 8);
        add(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3, 0, 8'hC0, 8);
        add(16'h0050, 4'h0, 4'h0, 1'b0, 2'd3, 3, 8'hC0, 8);
        add(16'h0500, 4'h0, 4'h0, 1'b1, 2'd3, 1, 8'hC0, 8);
        add(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 1, 8'hFF, 8);
        add(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 0, 8'hC0, 8);
        add(16'h0050, 4'h8, 4'h0, 1'b1, 2'd3, 3, 8'h7F, 8);
        add(16'h1234, 4'h0, 4'h0, 1'b0, 2'd0, 1, 8'hB0, 2);
        add(16'h1234, 4'h0, 4'h0, 1'b0, 2'd2, 2, 8'hA4, 6);
        add(16'h1234, 4'h0, 4'h0, 1'b0, 2'd1, 3, 8'hF9, 4);
        add(16'h1234, 4'h1, 4'h0, 1'b0, 2'd3, 0, 8'h19, 8);
        add(16'h1234, 4'h1, 4'h0, 1'b0, 2'd3, 1, 8'hB0, 8);
        add(16'h1234, 4'h4, 4'h4, 1'b0, 2'd3, 2, 8'hFF, 8);
        add(16'h1234, 4'h4, 4'h4, 1'b0, 2'd3, 3, 8'hF9, 8);
        add(16'h89EF, 4'h0, 4'h0, 1'b0, 2'd3, 0, 8'h8E, 8);
        add(16'h89EF, 4'h0, 4'h0, 1'b0, 2'd3, 1, 8'h86, 8);
        add(16'h89EF, 4'h0, 4'h0, 1'b0, 2'd3, 2, 8'h90, 8);
        add(16'h89EF, 4'h0, 4'h0, 1'b0, 2'd3, 3, 8'h80, 8);
        add(16'hDB76, 4'h0, 4'h0, 1'b0, 2'd3, 0, 8'h82, 8);
        add(16'hDB76, 4'h0, 4'h0, 1'b0, 2'd3, 1, 8'hF8, 8);
        add(16'hDB76, 4'h0, 4'h0, 1'b0, 2'd3, 2, 8'h83, 8);
        add(16'hDB76, 4'h0, 4'h0, 1'b0, 2'd3, 3, 8'hA1, 8);
        add(16'hC5A0, 4'h0, 4'h0, 1'b0, 2'd3, 1, 8'h88, 8);
        add(16'hC5A0, 4'h0, 4'h0, 1'b0, 2'd3, 2, 8'h92, 8);
        add(16'hC5A0, 4'h0, 4'h0, 1'b0, 2'd3, 3, 8'hC6, 8);

        // Reset state and first slot after release
        hex_in = 16'h1234;
        brightness = 2'd3;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_an", {28'h0, an}, 32'hF);
        check("reset_sseg", {24'h0, sseg}, 32'hFF);
        check("reset_tick", {31'h0, frame_tick}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("first_an", {28'h0, an}, 32'hE);
        check("first_sseg", {24'h0, sseg}, 32'h99);

        // Table-driven slot checks, one fresh frame per vector
        foreach (vecs[v]) begin
            hex_in = vecs[v].hex;
            dp_in = vecs[v].dp;
            blank_in = vecs[v].blank;
            lz_en = vecs[v].lz;
            brightness = vecs[v].bright;
            do_reset(2);
            an_exp = 4'hF ^ (4'h1 << vecs[v].digit);
            seg_act = vecs[v].exp_sseg;
            an_act = an_exp;
            on_cnt = 0;
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                if (k / 8 == int'(vecs[v].digit) && an !== 4'hF) begin
                    on_cnt++;
                    if (an !== an_exp && an_act === an_exp) an_act = an;
                    if (sseg !== vecs[v].exp_sseg && seg_act === vecs[v].exp_sseg) seg_act = sseg;
                end
            end
            check($sformatf("vec%0d_sseg", v), {24'h0, seg_act}, {24'h0, vecs[v].exp_sseg});
            check($sformatf("vec%0d_an", v), {28'h0, an_act}, {28'h0, an_exp});
            check($sformatf("vec%0d_on_cycles", v), on_cnt, vecs[v].exp_on);
        end

        // Frame coherence: a change at cycle 12 only shows from cycle 32
        old_exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        new_exp = '{8'hA1, 8'hC6, 8'h83, 8'h88};
        hex_in = 16'h1234; dp_in = 4'h0; blank_in = 4'h0; lz_en = 1'b0; brightness = 2'd3;
        do_reset(2);
        begin
            logic [7:0] bad0;
            logic [7:0] bad1;
            bad0 = 8'h00;
            bad1 = 8'h00;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                if (k < 32) begin
                    if (sseg !== old_exp[(k / 8) % 4] && bad0 == 8'h00) bad0 = sseg ^ old_exp[(k / 8) % 4];
                end else begin
                    if (sseg !== new_exp[(k / 8) % 4] && bad1 == 8'h00) bad1 = sseg ^ new_exp[(k / 8) % 4];
                end
                if (k == 12) hex_in = 16'hABCD;
            end
            check("coherent_frame0_diff", {24'h0, bad0}, 32'h0);
            check("coherent_frame1_diff", {24'h0, bad1}, 32'h0);
        end

        // frame_tick period and width
        hex_in = 16'h1234;
        do_reset(2);
        pulses = 0; first_pulse = 0; last_pulse = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (pulses == 0) first_pulse = k;
                last_pulse = k;
                pulses++;
            end
        end
        check("tick_count", pulses, 2);
        check("tick_first", first_pulse, 31);
        check("tick_second", last_pulse, 63);

        // Reset asserted mid-frame at cycle 45
        do_reset(2);
        for (int k = 0; k <= 45; k++) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midreset_an%0d", k), {28'h0, an}, 32'hF);
            check($sformatf("midreset_sseg%0d", k), {24'h0, sseg}, 32'hFF);
            check($sformatf("midreset_tick%0d", k), {31'h0, frame_tick}, 32'h0);
        end
        hex_in = 16'h5678;
        reset = 1'b0;
        @(negedge clk);
        check("restart_an", {28'h0, an}, 32'hE);
        check("restart_sseg", {24'h0, sseg}, 32'h80);
        pulses = 0; first_pulse = 0;
        for (int k = 1; k < 40 && pulses == 0; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                first_pulse = k;
                pulses++;
            end
        end
        check("restart_tick_seen", pulses, 1);
        check("restart_tick_pos", first_pulse, 31);

        check("an_onehot_violations", multi_an, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
